// File: rtl/mips_cpu_harvard_pkg.sv
// Shared definitions for the Harvard MIPS core: HI/LO multiply/divide op
// codes, sequencer states and iteration count, plus a magnitude helper.
package mips_cpu_harvard_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } muldiv_state_t;

   localparam int unsigned MULDIV_ITERATIONS = 32;

   // Two's-complement magnitude; 0x8000_0000 maps to itself (unsigned 2^31).
   function automatic logic [31:0] mag32(input logic [31:0] x);
      return x[31] ? -x : x;
   endfunction

endpackage

// File: rtl/mips_cpu_harvard_muldiv.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
// MULT/MULTU: 32 shift-add steps; DIV/DIVU: 32 restoring steps; one FIX
// cycle applies signs and writes HI/LO. MTHI/MTLO write in one cycle.
// Macro MIPS_CPU_HARVARD_MULDIV_DIV_EN enables the divider; when undefined
// DIV/DIVU are ignored like unused op codes.
module mips_cpu_harvard_muldiv
   import mips_cpu_harvard_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   muldiv_state_t state;
   muldiv_op_t    op_e;
   logic [5:0]    cnt;
   logic [63:0]   prod;      // product, or {remainder, quotient} while dividing
   logic [31:0]   a_reg;
   logic [31:0]   b_reg;
   logic          neg_res;
   logic          op_signed;
   logic [32:0]   mul_sum;
   logic [63:0]   mul_next;
   logic [63:0]   mul_fix;

`ifdef MIPS_CPU_HARVARD_MULDIV_DIV_EN
   logic          is_div;
   logic          neg_rem;
   logic [32:0]   div_tmp;
   logic          div_ge;
   logic [31:0]   div_rem;
   logic [63:0]   div_next;
   logic [31:0]   div_q_fix;
   logic [31:0]   div_r_fix;
`endif

   assign op_e      = muldiv_op_t'(op);
   assign op_signed = (op_e == OP_MULT) || (op_e == OP_DIV);

   // Step and sign-fix datapath for the current register contents.
   always_comb begin
      mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_reg} : 33'd0);
      mul_next = {mul_sum, prod[31:1]};
      mul_fix  = neg_res ? -prod : prod;
`ifdef MIPS_CPU_HARVARD_MULDIV_DIV_EN
      div_tmp   = {prod[63:32], prod[31]};
      div_ge    = div_tmp >= {1'b0, b_reg};
      div_rem   = div_ge ? (div_tmp[31:0] - b_reg) : div_tmp[31:0];
      div_next  = {div_rem, prod[30:0], div_ge};
      div_r_fix = neg_rem ? -prod[63:32] : prod[63:32];
      if (b_reg == '0)
         div_q_fix = '1;
      else
         div_q_fix = neg_res ? -prod[31:0] : prod[31:0];
`endif
   end

   // Sequencer FSM with registered busy/done and the HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         prod    <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         neg_res <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef MIPS_CPU_HARVARD_MULDIV_DIV_EN
         is_div  <= 1'b0;
         neg_rem <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  case (op_e)
                     OP_MULT, OP_MULTU: begin
                        a_reg   <= op_signed ? mag32(A) : A;
                        b_reg   <= op_signed ? mag32(B) : B;
                        prod    <= {32'd0, (op_signed ? mag32(B) : B)};
                        neg_res <= op_signed && (A[31] ^ B[31]);
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_MUL;
`ifdef MIPS_CPU_HARVARD_MULDIV_DIV_EN
                        is_div  <= 1'b0;
`endif
                     end
`ifdef MIPS_CPU_HARVARD_MULDIV_DIV_EN
                     OP_DIV, OP_DIVU: begin
                        a_reg   <= op_signed ? mag32(A) : A;
                        b_reg   <= op_signed ? mag32(B) : B;
                        prod    <= {32'd0, (op_signed ? mag32(A) : A)};
                        neg_res <= op_signed && (A[31] ^ B[31]);
                        neg_rem <= op_signed && A[31];
                        is_div  <= 1'b1;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_DIV;
                     end
`endif
                     OP_MTHI: hi <= A;
                     OP_MTLO: lo <= A;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               prod <= mul_next;
               cnt  <= cnt + 6'd1;
               if (cnt == 6'(MULDIV_ITERATIONS - 1))
                  state <= ST_FIX;
            end
`ifdef MIPS_CPU_HARVARD_MULDIV_DIV_EN
            ST_DIV: begin
               prod <= div_next;
               cnt  <= cnt + 6'd1;
               if (cnt == 6'(MULDIV_ITERATIONS - 1))
                  state <= ST_FIX;
            end
`endif
            ST_FIX: begin
`ifdef MIPS_CPU_HARVARD_MULDIV_DIV_EN
               if (is_div) begin
                  hi <= div_r_fix;
                  lo <= div_q_fix;
               end else begin
                  hi <= mul_fix[63:32];
                  lo <= mul_fix[31:0];
               end
`else
               hi <= mul_fix[63:32];
               lo <= mul_fix[31:0];
`endif
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mips_cpu_harvard_muldiv.md
# mips_cpu_harvard_muldiv

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the Harvard MIPS core. It executes MULT, MULTU, DIV and DIVU iteratively, and MTHI/MTLO in a single cycle. It sits beside the combinational ALU in the execute stage. The control path issues one operation with a start pulse and stalls the pipeline while `busy` is high.

## Interface
Parameters:
- none

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge system clock
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  issue request; sampled only in IDLE
- `op`  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6–7 are ignored
- `A`  in  32  rs operand (multiplicand, dividend or move source)
- `B`  in  32  rt operand (multiplier or divisor)
- `busy`  out  1  high while an iterative op is in flight
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in that cycle
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, MUL, DIV, FIX.
- Operand latch:
  - IDLE with start=1 and op = MULT, MULTU, DIV or DIVU: latch |A| and |B|, plus the result-sign flags.
  - Magnitudes and sign flags apply to signed ops only; unsigned ops latch A and B raw.
  - Clear the 6-bit iteration counter.
  - Go to MUL or DIV.
- MUL: one shift-add step per cycle over a 64-bit product register. After 32 steps go to FIX.
- DIV: one restoring step per cycle, producing a 32-bit remainder and 32-bit quotient. After 32 steps go to FIX.
- FIX:
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - Go to IDLE.
- MTHI/MTLO: in IDLE with start=1, write A into hi (MTHI) or lo (MTLO) at the next edge. No busy, no done.
- start in MUL/DIV/FIX: ignored; in-flight op unaffected. The control path must not issue while busy.
- op codes 6–7 with start=1: no effect.
- Divide by zero, signed and unsigned: HI = A, LO = 32'hFFFF_FFFF. Normal latency, no exception.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- All arithmetic is modulo 2^32 per register. The product is full-width 64-bit, with no truncation before FIX.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0.
- Reset in any state aborts the op; the reset values above apply from the next edge.
- Iterative op latency:
  - Start sampled at edge 0.
  - busy=1 for cycles 1–33 (32 iteration cycles plus FIX).
  - HI/LO update at the edge ending cycle 33.
  - done=1 and busy=0 in cycle 34.
- A new start is accepted in cycle 34, the same cycle as done; back-to-back issue is legal.
- MTHI/MTLO: 1-cycle latency; the value is visible on hi/lo in the cycle after start.
- hi/lo hold their old value throughout an iterative op until the FIX write.
- done is never high while busy is high.

## Configuration
- Macro: `MIPS_CPU_HARVARD_MULDIV_DIV_EN`.
- Defined: full DIV/DIVU support as above.
- Undefined:
  - DIV state and divider datapath are compiled out.
  - DIV/DIVU with start=1 is treated as ignored: no busy, no done, HI/LO unchanged.
  - MULT, MULTU, MTHI and MTLO are unaffected.

## Structure
- The shared package `mips_cpu_harvard_pkg` holds:
  - `muldiv_op_t`, the 3-bit enum of op codes above; the decoder uses the same enum.
  - `muldiv_state_t`.
  - Constant `MULDIV_ITERATIONS` = 32.
- No sub-module: the counter, the datapath registers and the FSM live in one module.
- The control path reads hi/lo directly for MFHI/MFLO.

## Test plan
- MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF -> cycle 34: done=1, hi=0xFFFF_FFFE, lo=0x0000_0001; busy high for exactly cycles 1–33.
- MULT A=0xFFFF_FFFD (−3), B=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; then DIV A=0xFFFF_FFF9 (−7), B=2 issued in the done cycle -> hi=0xFFFF_FFFF, lo=0xFFFF_FFFD.
- DIVU A=100, B=0 -> hi=0x0000_0064, lo=0xFFFF_FFFF; DIV A=0x8000_0000, B=0xFFFF_FFFF -> hi=0, lo=0x8000_0000.
- MTHI A=0x1234_5678, then MTLO A=0xCAFE_F00D on consecutive cycles -> hi/lo updated one cycle after each start; busy and done never asserted.
- MULTU 5×6 started; at cycle 10 pulse start with MTLO A=0xDEAD -> ignored; final lo=30, hi=0.
- DIVU 1000/3 started; reset at cycle 15 -> next cycle hi=lo=0, busy=0, done stays 0; a fresh MULTU 2×3 afterwards gives lo=6 at cycle 34.
